// File: rtl/nn_input_deserializer.sv
// Word-stream to parallel-vector deserializer feeding the neural_network top.
// Two ping-pong slots let the next frame fill while the current vector waits for the consumer.
module nn_input_deserializer #(
  parameter int NUM_DATA_INPUTS  = 4,
  parameter int INPUT_DATA_WIDTH = 16
) (
  input  logic                                               ap_clk,
  input  logic                                               ap_rst_n,
  input  logic                                               s_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]                        s_data,
  input  logic                                               s_last,
  output logic                                               s_ready,
  output logic                                               data_out_valid,
  output logic [NUM_DATA_INPUTS-1:0][INPUT_DATA_WIDTH-1:0]   data_out,
  input  logic                                               data_out_ready,
  output logic                                               frame_error,
  input  logic                                               error_clr
);

  localparam int N  = NUM_DATA_INPUTS;
  localparam int W  = INPUT_DATA_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL, DISCARD} state_t;

  state_t                       r_state;
  logic [1:0][N-1:0][W-1:0]     r_slot;
  logic [1:0]                   r_full;
  logic                         r_wr_sel;
  logic                         r_rd_sel;
  logic [IW-1:0]                r_idx;
  logic                         r_frame_error;

  logic w_acc, w_pop, w_last_idx, w_err;

  assign s_ready        = (r_state == DISCARD) | ~r_full[r_wr_sel];
  assign data_out_valid = r_full[r_rd_sel];
  assign data_out       = r_slot[r_rd_sel];
  assign frame_error    = r_frame_error;

  assign w_acc      = s_valid & s_ready;
  assign w_pop      = data_out_valid & data_out_ready;
  assign w_last_idx = (r_idx == IW'(N - 1));
  // Short frame (last too early) or long frame (no last on the final slot word).
  assign w_err      = w_acc & (r_state == FILL) & (s_last ^ w_last_idx);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= FILL;
      r_slot        <= '0;
      r_full        <= '0;
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_idx         <= '0;
      r_frame_error <= 1'b0;
    end else begin
      // A pop and a commit never target the same slot, so both bit updates can land.
      if (w_pop) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
      end

      if (w_err)          r_frame_error <= 1'b1;
      else if (error_clr) r_frame_error <= 1'b0;

      if (w_acc) begin
        case (r_state)
          FILL: begin
            if (s_last && !w_last_idx) begin
              r_idx <= '0;
            end else begin
              r_slot[r_wr_sel][r_idx] <= s_data;
              if (w_last_idx) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
                r_idx            <= '0;
                if (!s_last) r_state <= DISCARD;
              end else begin
                r_idx <= r_idx + IW'(1);
              end
            end
          end
          DISCARD: begin
            if (s_last) begin
              r_state <= FILL;
              r_idx   <= '0;
            end
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: doc/nn_input_deserializer.md
Name: nn_input_deserializer

Overview:
- Upstream feeder for the generated `neural_network` top.
- Accepts a narrow valid/ready word stream (one `INPUT_DATA_WIDTH` word per beat, `s_last` framing) and assembles `NUM_DATA_INPUTS` words into the parallel `data_in` array the network consumes.
- Ping-pong double buffering lets the next vector fill while the current one waits for `ap_ready`.
- Framing errors are detected, flagged and resynchronised so the network never sees a misaligned vector.

Parameters:
- NUM_DATA_INPUTS, 4, words per input vector (>=1); equals the network's NUM_DATA_INPUTS.
- INPUT_DATA_WIDTH, 16, bits per word; equals the network's INPUT_DATA_WIDTH.

Ports:
- ap_clk  in  1  clock; all logic rising-edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- s_valid  in  1  input word valid.
- s_data  in  INPUT_DATA_WIDTH  input word.
- s_last  in  1  marks final word of a vector.
- s_ready  out  1  block can accept a word.
- data_out_valid  out  1  complete vector available; drives the network's `data_in_valid`/`ap_start`.
- data_out  out  [INPUT_DATA_WIDTH-1:0] x NUM_DATA_INPUTS  assembled vector; element k = k-th word of the frame.
- data_out_ready  in  1  consumer accepts; tied to the network's `ap_ready`.
- frame_error  out  1  sticky framing-error flag.
- error_clr  in  1  synchronous clear of `frame_error`.

Behaviour:
- Reset (ap_rst_n=0, async): both slot-full flags=0, wr_sel=rd_sel=0, idx=0, state=FILL, frame_error=0, all slot data=0.
  - Outputs during reset: s_ready=1, data_out_valid=0, data_out=0.
  - Reset asserted mid-frame or with a vector pending discards everything.
- Storage: two slots of NUM_DATA_INPUTS words.
  - wr_sel selects the slot being filled; rd_sel selects the slot presented.
  - idx counts 0..NUM_DATA_INPUTS-1 within the fill slot.
- Input accept: a word is accepted when s_valid & s_ready.
  - In FILL, s_ready = ~full[wr_sel].
  - In DISCARD, s_ready = 1.
- FILL, accepted word, idx < N-1, s_last=0: write slot[wr_sel][idx]; idx++.
- FILL, accepted word, idx = N-1, s_last=1: write; full[wr_sel]=1; wr_sel toggles; idx=0.
- FILL, accepted word, idx < N-1, s_last=1 (short frame): word is dropped, the partial frame is discarded (slot not marked full), idx=0, frame_error=1, stay in FILL.
- FILL, accepted word, idx = N-1, s_last=0 (long frame): vector is committed as in the normal case, frame_error=1, state goes to DISCARD.
- DISCARD: accepted words are dropped; on an accepted word with s_last=1, go to FILL (idx=0).
- N=1: every word must carry s_last=1; s_last=0 follows the long-frame path.
- Output:
  - data_out_valid = full[rd_sel]; data_out = slot[rd_sel].
  - Registered: a vector completing on edge t is visible with valid=1 after edge t (1-cycle latency from the last word's accept).
  - On data_out_valid & data_out_ready: full[rd_sel]=0 and rd_sel toggles.
  - data_out and data_out_valid hold stable while valid & ~ready.
- Simultaneous completion and pop on the same edge (different slots) both take effect.
  - Back-to-back throughput: one word per cycle sustained when data_out_ready is held high.
- Full condition: both slots full gives s_ready=0 in FILL. s_ready rises the cycle after a pop; there is no combinational ready-to-ready path.
- frame_error: set on any framing error; cleared by error_clr. If set and clear coincide, set wins.
- No arithmetic on data; words pass through bit-exact.

Test Plan:
- Reset, then with N=4, W=16, stream 1,2,3,4 (s_last on 4), data_out_ready=1 -> data_out_valid for 1 cycle, one cycle after word 4 accepted, data_out={4,3,2,1} (element 0 = 1), frame_error=0.
- data_out_ready=0, stream 3 frames (12 words) back-to-back -> s_ready falls after word 8 accepted; two vectors held stable; raise ready -> vectors popped in order, third frame accepted, nothing lost or duplicated.
- Short frame 0xA,0xB with s_last on 0xB, then good frame 5,6,7,8 -> frame_error=1; only {8,7,6,5} emitted.
- Long frame 1..6 with s_last on 6, then 9,10,11,12 -> {4,3,2,1} emitted, words 5 and 6 dropped, {12,11,10,9} emitted, frame_error=1; pulsing error_clr then gives 0.
- Async reset asserted after 2 words of a frame with one vector pending -> data_out_valid=0 immediately; after release, a fresh frame 1,2,3,4 gives {4,3,2,1}.
- error_clr asserted on the same edge as a short-frame error -> frame_error remains 1.
